// File: rtl/imem_arbiter_if.sv
// rtl/imem_arbiter_if.sv - fetch, loader and instruction-memory signals of the imem arbiter
interface imem_arbiter_if #(
  parameter int WORDS = 256,
  parameter int IW    = $clog2(WORDS)
);
  logic          fetch_req;
  logic [31:0]   fetch_addr;
  logic          fetch_ack;
  logic [31:0]   fetch_data;
  logic          fetch_fault;

  logic          load_req;
  logic          load_we;
  logic [31:0]   load_addr;
  logic [31:0]   load_wdata;
  logic          load_ack;
  logic [31:0]   load_rdata;
  logic          load_fault;

  logic          mem_en;
  logic          mem_we;
  logic [IW-1:0] mem_index;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  modport slave (
    input  fetch_req, fetch_addr, load_req, load_we, load_addr, load_wdata, mem_rdata,
    output fetch_ack, fetch_data, fetch_fault, load_ack, load_rdata, load_fault,
           mem_en, mem_we, mem_index, mem_wdata
  );

  modport master (
    output fetch_req, fetch_addr, load_req, load_we, load_addr, load_wdata, mem_rdata,
    input  fetch_ack, fetch_data, fetch_fault, load_ack, load_rdata, load_fault,
           mem_en, mem_we, mem_index, mem_wdata
  );
endinterface

// File: rtl/imem_arbiter.sv
// rtl/imem_arbiter.sv - shares the single-port instruction memory between fetch and loader
module imem_arbiter #(
  parameter int          WORDS            = 256,
  parameter logic [31:0] BASE             = 32'h00400000,
  parameter int          MAX_LOADER_BURST = 4
) (
  input  logic           clock,
  input  logic           clear,
  imem_arbiter_if.slave  bus
);
  localparam int          IW        = $clog2(WORDS);
  localparam int          BW        = $clog2(MAX_LOADER_BURST + 1);
  localparam logic [31:0] SPAN      = 32'(4 * WORDS);
  localparam logic [BW-1:0] BURST_MAX = BW'(MAX_LOADER_BURST);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t        state;
  logic [BW-1:0] burst_cnt;
  logic          owner_load;
  logic          resp_read;
  logic          fetch_ack_q, load_ack_q, fetch_fault_q, load_fault_q;
  logic          mem_en_q, mem_we_q;
  logic [IW-1:0] mem_index_q;
  logic [31:0]   mem_wdata_q;

  logic          grant_load, grant_fetch, g_we, g_valid;
  logic [31:0]   g_addr, g_off;
  logic [IW-1:0] g_index;

  // Loader has priority until it has won MAX_LOADER_BURST times in a row over a waiting fetch.
  always_comb begin
    grant_load  = bus.load_req && (!bus.fetch_req || burst_cnt != BURST_MAX);
    grant_fetch = bus.fetch_req && !grant_load;
    g_addr      = grant_load ? bus.load_addr : bus.fetch_addr;
    g_we        = grant_load && bus.load_we;
    g_off       = g_addr - BASE;
    g_valid     = (g_addr >= BASE) && (g_off < SPAN) && (g_addr[1:0] == 2'b00);
    g_index     = IW'(g_off >> 2);
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state         <= IDLE;
      burst_cnt     <= '0;
      owner_load    <= 1'b0;
      resp_read     <= 1'b0;
      fetch_ack_q   <= 1'b0;
      load_ack_q    <= 1'b0;
      fetch_fault_q <= 1'b0;
      load_fault_q  <= 1'b0;
      mem_en_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_index_q   <= '0;
      mem_wdata_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_load || grant_fetch) begin
            owner_load <= grant_load;
            resp_read  <= g_valid && !g_we;
            if (grant_load && bus.fetch_req) begin
              if (burst_cnt != BURST_MAX)
                burst_cnt <= burst_cnt + BW'(1);
            end else begin
              burst_cnt <= '0;
            end
            if (g_valid) begin
              state       <= ACCESS;
              mem_en_q    <= 1'b1;
              mem_we_q    <= g_we;
              mem_index_q <= g_index;
              mem_wdata_q <= grant_load ? bus.load_wdata : 32'h0;
            end else begin
              // Rejected addresses skip the memory entirely and answer next cycle.
              state         <= RESP;
              fetch_ack_q   <= grant_fetch;
              load_ack_q    <= grant_load;
              fetch_fault_q <= grant_fetch;
              load_fault_q  <= grant_load;
            end
          end
        end
        ACCESS: begin
          state       <= RESP;
          mem_en_q    <= 1'b0;
          mem_we_q    <= 1'b0;
          fetch_ack_q <= !owner_load;
          load_ack_q  <= owner_load;
        end
        RESP: begin
          state         <= IDLE;
          fetch_ack_q   <= 1'b0;
          load_ack_q    <= 1'b0;
          fetch_fault_q <= 1'b0;
          load_fault_q  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read data passes straight from the memory during the ack cycle.
  assign bus.fetch_data  = (fetch_ack_q && resp_read) ? bus.mem_rdata : 32'h0;
  assign bus.load_rdata  = (load_ack_q && resp_read) ? bus.mem_rdata : 32'h0;
  assign bus.fetch_ack   = fetch_ack_q;
  assign bus.load_ack    = load_ack_q;
  assign bus.fetch_fault = fetch_fault_q;
  assign bus.load_fault  = load_fault_q;
  assign bus.mem_en      = mem_en_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.mem_index   = mem_index_q;
  assign bus.mem_wdata   = mem_wdata_q;
endmodule

// File: tb/tb_imem_arbiter.sv
// tb/tb_imem_arbiter.sv - directed scoreboard bench for imem_arbiter
module tb_imem_arbiter;
  localparam int          WORDS = 256;
  localparam logic [31:0] BASE  = 32'h00400000;

  typedef struct {
    bit          ld;
    bit          fault;
    logic [31:0] data;
  } resp_t;

  typedef struct {
    bit          we;
    logic [7:0]  idx;
    logic [31:0] wdata;
  } memop_t;

  logic clock = 1'b0;
  logic clear = 1'b0;
  always #5 clock = ~clock;

  imem_arbiter_if #(.WORDS(WORDS)) bus ();

  imem_arbiter #(
    .WORDS(WORDS),
    .BASE(BASE),
    .MAX_LOADER_BURST(4)
  ) dut (
    .clock(clock),
    .clear(clear),
    .bus(bus)
  );

  resp_t       resp_q[$];
  memop_t      mem_q[$];
  logic [31:0] mem[WORDS];
  logic [31:0] exp_mem[WORDS];
  logic [31:0] rdata_q = 32'h0;
  int          checks = 0;
  int          errors = 0;
  int          ack_count = 0;

  assign bus.mem_rdata = rdata_q;

  always @(posedge clock) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_index] = bus.mem_wdata;
      else rdata_q <= mem[bus.mem_index];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit addr_ok(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'(4 * WORDS)) && (a[1:0] == 2'b00);
  endfunction

  function automatic logic [7:0] addr_idx(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return off[9:2];
  endfunction

  always @(negedge clock) begin
    memop_t m;
    resp_t  r;
    if (bus.mem_en) begin
      chk("mem_en_expected", (mem_q.size() == 0) ? 32'd0 : 32'd1, 32'd1);
      if (mem_q.size() != 0) begin
        m = mem_q.pop_front();
        chk("mem_we", 32'(bus.mem_we), 32'(m.we));
        chk("mem_index", 32'(bus.mem_index), 32'(m.idx));
        if (m.we) chk("mem_wdata", bus.mem_wdata, m.wdata);
      end
    end
    if (bus.fetch_ack || bus.load_ack) begin
      ack_count++;
      chk("ack_expected", (resp_q.size() == 0) ? 32'd0 : 32'd1, 32'd1);
      if (resp_q.size() != 0) begin
        r = resp_q.pop_front();
        chk("ack_owner", 32'({bus.load_ack, bus.fetch_ack}), r.ld ? 32'd2 : 32'd1);
        if (r.ld) begin
          chk("load_fault", 32'(bus.load_fault), 32'(r.fault));
          chk("load_rdata", bus.load_rdata, r.data);
          chk("idle_fetch_side", {bus.fetch_data[30:0], bus.fetch_fault}, 32'h0);
        end else begin
          chk("fetch_fault", 32'(bus.fetch_fault), 32'(r.fault));
          chk("fetch_data", bus.fetch_data, r.data);
          chk("idle_load_side", {bus.load_rdata[30:0], bus.load_fault}, 32'h0);
        end
      end
    end
  end

  // One request from idle to ack; checks the ack latency and leaves one idle cycle behind.
  task automatic do_req(input bit ld, input bit we, input logic [31:0] addr, input logic [31:0] wd);
    resp_t  r;
    memop_t m;
    bit     ok;
    int     n;
    ok = addr_ok(addr);
    r.ld = ld;
    r.fault = !ok;
    r.data = (ok && !(ld && we)) ? exp_mem[addr_idx(addr)] : 32'h0;
    if (ok) begin
      m.we = ld && we;
      m.idx = addr_idx(addr);
      m.wdata = wd;
      mem_q.push_back(m);
      if (ld && we) exp_mem[addr_idx(addr)] = wd;
    end
    resp_q.push_back(r);
    if (ld) begin
      bus.load_req = 1'b1; bus.load_we = we; bus.load_addr = addr; bus.load_wdata = wd;
    end else begin
      bus.fetch_req = 1'b1; bus.fetch_addr = addr;
    end
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!(ld ? bus.load_ack : bus.fetch_ack) && n < 8);
    chk(ld ? "load_latency" : "fetch_latency", 32'(n), ok ? 32'd2 : 32'd1);
    bus.load_req = 1'b0;
    bus.load_we = 1'b0;
    bus.fetch_req = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    resp_t  r;
    memop_t m;
    int     n;
    int     base_cnt;

    bus.fetch_req = 1'b0; bus.fetch_addr = 32'h0;
    bus.load_req = 1'b0; bus.load_we = 1'b0; bus.load_addr = 32'h0; bus.load_wdata = 32'h0;
    for (int i = 0; i < WORDS; i++) mem[i] = 32'h10000000 + 32'(i) * 32'h00010001;
    mem[2] = 32'h2210FFFF;
    mem[255] = 32'hDEADBEEF;
    for (int i = 0; i < WORDS; i++) exp_mem[i] = mem[i];

    #12;
    chk("rst_fetch_ack", 32'(bus.fetch_ack), 32'h0);
    chk("rst_load_ack", 32'(bus.load_ack), 32'h0);
    chk("rst_faults", 32'({bus.fetch_fault, bus.load_fault}), 32'h0);
    chk("rst_mem_en_we", 32'({bus.mem_en, bus.mem_we}), 32'h0);
    chk("rst_mem_index", 32'(bus.mem_index), 32'h0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'h0);
    chk("rst_fetch_data", bus.fetch_data, 32'h0);
    chk("rst_load_rdata", bus.load_rdata, 32'h0);
    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);

    do_req(1'b0, 1'b0, 32'h00400008, 32'h0);
    do_req(1'b1, 1'b1, 32'h00400004, 32'h36108000);
    do_req(1'b0, 1'b0, 32'h00400004, 32'h0);
    do_req(1'b0, 1'b0, 32'h00400400, 32'h0);
    do_req(1'b0, 1'b0, 32'h00400002, 32'h0);
    do_req(1'b0, 1'b0, 32'h003FFFFC, 32'h0);
    do_req(1'b1, 1'b0, 32'h0040001C, 32'h0);
    do_req(1'b1, 1'b1, 32'h00400401, 32'h55555555);
    do_req(1'b1, 1'b0, 32'h00400004, 32'h0);

    // Both requesters held: expect L,L,L,L,F twice, one transaction every 3 cycles.
    for (int k = 0; k < 10; k++) begin
      r.ld = (k % 5) != 4;
      r.fault = 1'b0;
      m.we = 1'b0;
      m.idx = r.ld ? 8'd5 : 8'd3;
      m.wdata = 32'h0;
      r.data = exp_mem[m.idx];
      resp_q.push_back(r);
      mem_q.push_back(m);
    end
    base_cnt = ack_count;
    bus.load_req = 1'b1; bus.load_we = 1'b0; bus.load_addr = BASE + 32'd20;
    bus.fetch_req = 1'b1; bus.fetch_addr = BASE + 32'd12;
    n = 0;
    while (ack_count - base_cnt < 10 && n < 60) begin
      @(negedge clock);
      #1;
      n++;
    end
    chk("burst_cycles", 32'(n), 32'd29);
    bus.load_req = 1'b0;
    bus.fetch_req = 1'b0;
    @(negedge clock);

    // Reset during a loader write access, then re-grant of the still-pending request.
    m.we = 1'b1; m.idx = 8'd16; m.wdata = 32'hC0DE1234;
    mem_q.push_back(m);
    bus.load_req = 1'b1; bus.load_we = 1'b1; bus.load_addr = BASE + 32'd64; bus.load_wdata = 32'hC0DE1234;
    @(negedge clock);
    chk("clr_pre_mem_en", 32'(bus.mem_en), 32'h1);
    #1 clear = 1'b0;
    #1;
    chk("clr_mem_en", 32'({bus.mem_en, bus.mem_we}), 32'h0);
    chk("clr_load_ack", 32'(bus.load_ack), 32'h0);
    @(negedge clock);
    #1;
    chk("clr_hold_ack", 32'(bus.load_ack), 32'h0);
    clear = 1'b1;
    mem_q.push_back(m);
    r.ld = 1'b1; r.fault = 1'b0; r.data = 32'h0;
    resp_q.push_back(r);
    exp_mem[16] = 32'hC0DE1234;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!bus.load_ack && n < 8);
    chk("clr_regrant_latency", 32'(n), 32'd2);
    bus.load_req = 1'b0;
    bus.load_we = 1'b0;
    @(negedge clock);

    do_req(1'b0, 1'b0, 32'h00400040, 32'h0);
    do_req(1'b0, 1'b0, 32'h004003FC, 32'h0);

    repeat (3) @(negedge clock);
    chk("resp_q_drained", 32'(resp_q.size()), 32'h0);
    chk("mem_q_drained", 32'(mem_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
